bus_controller: RTL and testbench
=================================

BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 Parameter RAM_ADDR_BITS, default 12, word-address width of the RAM port (4 KWords).
REQ-002 Parameter IO_BASE, default 32'hF000_0000, base of the 256-word IO window.
REQ-003 Parameter IO_TIMEOUT, default 16, maximum cycles to wait for ioReady.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpuAddress  in  32  CPU byte address.
REQ-007 cpuDataOut  in  32  CPU write data.
REQ-008 cpuDataIn  out  32  read data returned to the CPU.
REQ-009 cpuBusValid  in  1  CPU requests a transaction.
REQ-010 cpuBusInstr  in  1  1 = instruction fetch, 0 = data access.
REQ-011 cpuBusWriteEnable  in  1  1 = write, 0 = read.
REQ-012 cpuBusReady  out  1  one-cycle completion pulse to the CPU.
REQ-013 ramAddress  out  RAM_ADDR_BITS  RAM word address, cpuAddress[RAM_ADDR_BITS+1:2].
REQ-014 ramDataOut / ramDataIn  out / in  32  RAM write / read data; RAM read latency is 1 cycle.
REQ-015 ramChipSelect, ramWriteEnable  out  1 each  RAM strobes.
REQ-016 ioAddress  out  8  IO word address, cpuAddress[9:2].
REQ-017 ioDataOut / ioDataIn  out / in  32  IO write / read data.
REQ-018 ioValid, ioWriteEnable  out  1 each  IO request strobes; ioReady in 1 IO completion.
REQ-019 busError  out  1  one-cycle pulse, coincident with cpuBusReady, on a failed transaction.
REQ-020 errorAddress  out  32  cpuAddress of the most recent failed transaction.

Function
REQ-021 States SHALL be IDLE, RAM_WAIT, IO_WAIT, DONE.
REQ-022 Decode: RAM region = cpuAddress < 4*2^RAM_ADDR_BITS; IO region = IO_BASE <= cpuAddress < IO_BASE+1024; all other addresses unmapped.
REQ-023 IDLE with cpuBusValid=1 SHALL latch address, write data, instr and write flags, then decode.
REQ-024 RAM hit: ramChipSelect=1 (ramWriteEnable = write flag) for exactly the accept cycle; next state RAM_WAIT.
REQ-025 RAM_WAIT SHALL capture ramDataIn into cpuDataIn on reads (cpuDataIn unchanged on writes); next state DONE.
REQ-026 IO hit (data access only): ioValid and ioWriteEnable held from the cycle after accept until ioReady is sampled high; next state IO_WAIT.
REQ-027 IO_WAIT SHALL capture ioDataIn on reads when ioReady=1, then go to DONE.
REQ-028 IO timeout: a down-counter loaded with IO_TIMEOUT at accept; on reaching 0 without ioReady, drop ioValid, set cpuDataIn=32'hFFFF_FFFF, flag error, go to DONE.
REQ-029 Error cases: unmapped address, instruction fetch from IO, write with cpuBusInstr=1, IO timeout; unmapped/illegal requests go IDLE->DONE directly with cpuDataIn=32'hDEAD_BEEF (reads) and no RAM/IO strobe.
REQ-030 DONE: cpuBusReady=1 for exactly one cycle, busError=1 if flagged, errorAddress updated on error; next state IDLE.
REQ-031 cpuBusValid is ignored outside IDLE; the CPU drops cpuBusValid the cycle after it samples cpuBusReady; a still-high cpuBusValid in IDLE starts a new transaction.
REQ-032 Latency from accept: RAM = 3 cycles to cpuBusReady; error = 2 cycles; IO = 3 + ioReady wait cycles.
REQ-033 ioReady asserted outside IO_WAIT SHALL be ignored.

Reset
REQ-034 reset=0 SHALL asynchronously force IDLE, every output to 0 (including cpuDataIn and errorAddress), and the timeout counter to 0.
REQ-035 Reset mid-transaction SHALL abort it, with no cpuBusReady or RAM/IO strobe in the cycle after release.

Verification
REQ-036 Read of 0x0000_0010 with RAM word 4 = 0x1234_5678 -> ramAddress=4, cpuDataIn=0x1234_5678, cpuBusReady 3 cycles after accept.
REQ-037 Write of 0xCAFE_F00D to 0xF000_0008, ioReady after 2 cycles -> ioAddress=2, ioWriteEnable=1, single cpuBusReady, busError=0.
REQ-038 Read of 0xF000_0000 with ioReady held low -> after IO_TIMEOUT cycles cpuDataIn=0xFFFF_FFFF, busError=1, errorAddress=0xF000_0000.
REQ-039 Fetch from 0x8000_0000 -> cpuDataIn=0xDEAD_BEEF, busError=1, no ramChipSelect or ioValid.
REQ-040 reset low during IO_WAIT -> all outputs 0 immediately; next request after release completes normally.
REQ-041 Back-to-back RAM reads with cpuBusValid held high -> exactly one cpuBusReady per transaction, no duplicate RAM access.

Source files
------------

// File: rtl/bus_controller_if.sv
// ----------------------------------------------------------------------------
// bus_controller_if
// CPU-side bus bundle for bus_controller.
//   cpuAddress        CPU byte address
//   cpuDataOut        CPU write data
//   cpuDataIn         read data returned to the CPU
//   cpuBusValid       transaction request
//   cpuBusInstr       1 = instruction fetch, 0 = data access
//   cpuBusWriteEnable 1 = write, 0 = read
//   cpuBusReady       one-cycle completion pulse
//   busError          one-cycle error pulse, coincident with cpuBusReady
//   errorAddress      address of the most recent failed transaction
// master = CPU side, slave = controller side.
// ----------------------------------------------------------------------------
interface bus_controller_if;
    logic [31:0] cpuAddress;
    logic [31:0] cpuDataOut;
    logic [31:0] cpuDataIn;
    logic        cpuBusValid;
    logic        cpuBusInstr;
    logic        cpuBusWriteEnable;
    logic        cpuBusReady;
    logic        busError;
    logic [31:0] errorAddress;

    modport master (
        output cpuAddress, cpuDataOut, cpuBusValid, cpuBusInstr, cpuBusWriteEnable,
        input  cpuDataIn, cpuBusReady, busError, errorAddress
    );

    modport slave (
        input  cpuAddress, cpuDataOut, cpuBusValid, cpuBusInstr, cpuBusWriteEnable,
        output cpuDataIn, cpuBusReady, busError, errorAddress
    );
endinterface

// File: rtl/bus_controller.sv
// ----------------------------------------------------------------------------
// bus_controller
// Decodes CPU bus requests onto a 1-cycle-latency RAM port or a
// ready-handshaked IO window; everything else is reported as a bus error.
//   clk / reset     clock, asynchronous active-low reset
//   cpu             CPU bus (bus_controller_if.slave)
//   ram*            RAM word port; strobes are asserted in the accept cycle
//   io*             IO port; ioValid held until ioReady or timeout
// ----------------------------------------------------------------------------
module bus_controller #(
    parameter int          RAM_ADDR_BITS = 12,
    parameter logic [31:0] IO_BASE       = 32'hF000_0000,
    parameter int          IO_TIMEOUT    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    bus_controller_if.slave          cpu,
    output logic [RAM_ADDR_BITS-1:0] ramAddress,
    output logic [31:0]              ramDataOut,
    input  logic [31:0]              ramDataIn,
    output logic                     ramChipSelect,
    output logic                     ramWriteEnable,
    output logic [7:0]               ioAddress,
    output logic [31:0]              ioDataOut,
    input  logic [31:0]              ioDataIn,
    output logic                     ioValid,
    output logic                     ioWriteEnable,
    input  logic                     ioReady
);
    localparam int          CW        = $clog2(IO_TIMEOUT + 1);
    localparam logic [32:0] RAM_LIMIT = 33'd4 << RAM_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, DONE} state_t;

    state_t         r_state, w_next;
    logic           r_live;      // low for the first cycle after reset release
    logic [31:0]    r_addr;
    logic           r_wr;
    logic [31:0]    r_dataIn;
    logic           r_ready, r_busErr;
    logic [31:0]    r_errAddr;
    logic           r_ioValid, r_ioWe;
    logic [7:0]     r_ioAddr;
    logic [31:0]    r_ioData;
    logic [CW-1:0]  r_cnt;

    logic        w_accept, w_isRam, w_isIo, w_illegal, w_ramHit;
    logic        w_err, w_timeout;
    logic [31:0] w_ioOff;

    // Decode works straight off the live CPU bus in the accept cycle so the
    // RAM can be strobed immediately; r_live keeps the first post-reset
    // cycle strobe-free even if the CPU already holds cpuBusValid.
    assign w_accept  = (r_state == IDLE) && r_live && cpu.cpuBusValid;
    assign w_isRam   = {1'b0, cpu.cpuAddress} < RAM_LIMIT;
    assign w_ioOff   = cpu.cpuAddress - IO_BASE;
    assign w_isIo    = (cpu.cpuAddress >= IO_BASE) && (w_ioOff < 32'd1024);
    assign w_illegal = (cpu.cpuBusInstr && cpu.cpuBusWriteEnable) ||
                       (cpu.cpuBusInstr && w_isIo) || (!w_isRam && !w_isIo);
    assign w_ramHit  = w_accept && w_isRam && !w_illegal;

    assign ramChipSelect  = w_ramHit;
    assign ramWriteEnable = w_ramHit && cpu.cpuBusWriteEnable;
    assign ramAddress     = w_ramHit ? cpu.cpuAddress[RAM_ADDR_BITS+1:2] : '0;
    assign ramDataOut     = (w_ramHit && cpu.cpuBusWriteEnable) ? cpu.cpuDataOut : '0;

    assign ioValid        = r_ioValid;
    assign ioWriteEnable  = r_ioWe;
    assign ioAddress      = r_ioAddr;
    assign ioDataOut      = r_ioData;

    assign cpu.cpuDataIn    = r_dataIn;
    assign cpu.cpuBusReady  = r_ready;
    assign cpu.busError     = r_busErr;
    assign cpu.errorAddress = r_errAddr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_err     = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: if (w_accept) begin
                if (w_illegal) begin
                    w_next = DONE;
                    w_err  = 1'b1;
                end else if (w_isRam) begin
                    w_next = RAM_WAIT;
                end else begin
                    w_next = IO_WAIT;
                end
            end
            RAM_WAIT: w_next = DONE;
            IO_WAIT: if (ioReady) begin
                w_next = DONE;
            end else if (r_cnt <= CW'(1)) begin
                // this is the last allowed wait cycle
                w_next    = DONE;
                w_timeout = 1'b1;
                w_err     = 1'b1;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live    <= 1'b0;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_dataIn  <= '0;
            r_ready   <= 1'b0;
            r_busErr  <= 1'b0;
            r_errAddr <= '0;
            r_ioValid <= 1'b0;
            r_ioWe    <= 1'b0;
            r_ioAddr  <= '0;
            r_ioData  <= '0;
            r_cnt     <= '0;
        end else begin
            r_live   <= 1'b1;
            r_ready  <= (w_next == DONE);
            r_busErr <= w_err;
            if (w_err) r_errAddr <= (r_state == IDLE) ? cpu.cpuAddress : r_addr;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_addr <= cpu.cpuAddress;
                    r_wr   <= cpu.cpuBusWriteEnable;
                    if (w_illegal) begin
                        if (!cpu.cpuBusWriteEnable) r_dataIn <= 32'hDEAD_BEEF;
                    end else if (!w_isRam) begin
                        r_ioValid <= 1'b1;
                        r_ioWe    <= cpu.cpuBusWriteEnable;
                        r_ioAddr  <= cpu.cpuAddress[9:2];
                        r_ioData  <= cpu.cpuDataOut;
                        r_cnt     <= CW'(IO_TIMEOUT);
                    end
                end
                RAM_WAIT: if (!r_wr) r_dataIn <= ramDataIn;
                IO_WAIT: begin
                    if (ioReady) begin
                        r_ioValid <= 1'b0;
                        r_ioWe    <= 1'b0;
                        r_cnt     <= '0;
                        if (!r_wr) r_dataIn <= ioDataIn;
                    end else if (w_timeout) begin
                        r_ioValid <= 1'b0;
                        r_ioWe    <= 1'b0;
                        r_cnt     <= '0;
                        r_dataIn  <= 32'hFFFF_FFFF;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_controller.sv
// ----------------------------------------------------------------------------
// tb_bus_controller
// Directed bench for bus_controller: RAM model with 1-cycle read latency,
// programmable-delay IO responder, per-scenario tasks with inline checks.
// ----------------------------------------------------------------------------
module tb_bus_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] ramAddress;
    logic [31:0] ramDataOut, ramDataIn;
    logic        ramChipSelect, ramWriteEnable;
    logic [7:0]  ioAddress;
    logic [31:0] ioDataOut;
    logic [31:0] ioDataIn = 32'h5A5A_0001;
    logic        ioValid, ioWriteEnable, ioReady;

    bus_controller_if bus ();

    bus_controller dut (
        .clk           (clk),
        .reset         (reset),
        .cpu           (bus),
        .ramAddress    (ramAddress),
        .ramDataOut    (ramDataOut),
        .ramDataIn     (ramDataIn),
        .ramChipSelect (ramChipSelect),
        .ramWriteEnable(ramWriteEnable),
        .ioAddress     (ioAddress),
        .ioDataOut     (ioDataOut),
        .ioDataIn      (ioDataIn),
        .ioValid       (ioValid),
        .ioWriteEnable (ioWriteEnable),
        .ioReady       (ioReady)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // RAM model: registered read, one cycle latency
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        if (ramChipSelect) begin
            if (ramWriteEnable) mem[ramAddress] <= ramDataOut;
            ramDataIn <= mem[ramAddress];
        end
    end

    // IO responder: raises ioReady after io_delay cycles of ioValid
    logic io_respond = 1'b0;
    logic io_force   = 1'b0;
    logic io_resp    = 1'b0;
    int   io_delay   = 0;
    int   io_wcnt    = 0;
    assign ioReady = io_resp | io_force;
    always @(negedge clk) begin
        if (ioValid && io_respond) begin
            io_resp = (io_wcnt == io_delay);
            io_wcnt++;
        end else begin
            io_resp = 1'b0;
            io_wcnt = 0;
        end
    end

    // activity monitor
    int          n_cs = 0, n_rdy = 0, n_iov = 0;
    logic [11:0] last_ram = '0;
    logic [7:0]  last_ioa = '0;
    logic        last_iowe = 1'b0;
    logic [31:0] last_iod = '0;
    always @(negedge clk) begin
        if (ramChipSelect) begin n_cs++; last_ram = ramAddress; end
        if (bus.cpuBusReady) n_rdy++;
        if (ioValid) begin
            n_iov++; last_ioa = ioAddress; last_iowe = ioWriteEnable; last_iod = ioDataOut;
        end
    end

    // Drive one request (caller is at posedge+1); lat counts cycles from the
    // accept cycle (=1) to the cycle cpuBusReady is seen; 0 means never.
    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic ins,
                           input logic we, output int lat, output logic [31:0] rd,
                           output logic er);
        bus.cpuAddress = a; bus.cpuDataOut = d; bus.cpuBusInstr = ins;
        bus.cpuBusWriteEnable = we; bus.cpuBusValid = 1'b1;
        lat = 0; rd = '0; er = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.cpuBusReady) begin
                lat = i; rd = bus.cpuDataIn; er = bus.busError;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.cpuBusValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.cpuBusValid = 1'b0; bus.cpuAddress = '0; bus.cpuDataOut = '0;
        bus.cpuBusInstr = 1'b0; bus.cpuBusWriteEnable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.cpuBusReady, bus.busError, ramChipSelect, ramWriteEnable, ioValid, ioWriteEnable} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 000000",
                {bus.cpuBusReady, bus.busError, ramChipSelect, ramWriteEnable, ioValid, ioWriteEnable});
        end
        total++;
        if (bus.cpuDataIn !== 32'h0 || bus.errorAddress !== 32'h0) begin
            bad++; $display("FAIL reset_data: got %h/%h want 0/0", bus.cpuDataIn, bus.errorAddress);
        end
        total++;
        if (ioAddress !== 8'h0 || ioDataOut !== 32'h0 || ramAddress !== 12'h0) begin
            bad++; $display("FAIL reset_addr: got io %h/%h ram %h want 0", ioAddress, ioDataOut, ramAddress);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ram_read();
        int lat; logic [31:0] rd; logic er; int c0;
        c0 = n_cs;
        run_req(32'h0000_0010, 32'h0, 1'b0, 1'b0, lat, rd, er);
        total++; if (lat !== 3) begin bad++; $display("FAIL ram_read_lat: got %0d want 3", lat); end
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL ram_read_data: got %h want 12345678", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL ram_read_err: got %b want 0", er); end
        total++; if (last_ram !== 12'd4) begin bad++; $display("FAIL ram_read_addr: got %h want 004", last_ram); end
        total++; if (n_cs - c0 !== 1) begin bad++; $display("FAIL ram_read_cs: got %0d want 1", n_cs - c0); end
    endtask

    task automatic test_ram_write_boundary();
        int lat; logic [31:0] rd; logic er;
        run_req(32'h0000_3FFC, 32'hA5A5_0FF0, 1'b0, 1'b1, lat, rd, er);
        total++; if (lat !== 3) begin bad++; $display("FAIL ram_write_lat: got %0d want 3", lat); end
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL ram_write_keep: got %h want 12345678", rd); end
        total++; if (last_ram !== 12'hFFF) begin bad++; $display("FAIL ram_write_addr: got %h want fff", last_ram); end
        // read back through an instruction fetch, which RAM allows
        run_req(32'h0000_3FFC, 32'h0, 1'b1, 1'b0, lat, rd, er);
        total++; if (rd !== 32'hA5A5_0FF0 || er !== 1'b0) begin
            bad++; $display("FAIL ram_fetch_back: got %h err %b want a5a50ff0 err 0", rd, er);
        end
    endtask

    task automatic test_io_write();
        int lat; logic [31:0] rd; logic er; int r0, v0;
        io_respond = 1'b1; io_delay = 2;
        r0 = n_rdy; v0 = n_iov;
        run_req(32'hF000_0008, 32'hCAFE_F00D, 1'b0, 1'b1, lat, rd, er);
        total++; if (lat !== 5) begin bad++; $display("FAIL io_write_lat: got %0d want 5", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL io_write_err: got %b want 0", er); end
        total++; if (last_ioa !== 8'd2 || last_iowe !== 1'b1) begin
            bad++; $display("FAIL io_write_addr: got %h we %b want 02 we 1", last_ioa, last_iowe);
        end
        total++; if (last_iod !== 32'hCAFE_F00D) begin bad++; $display("FAIL io_write_data: got %h want cafef00d", last_iod); end
        total++; if (n_rdy - r0 !== 1) begin bad++; $display("FAIL io_write_ready: got %0d want 1", n_rdy - r0); end
        total++; if (n_iov - v0 !== 3) begin bad++; $display("FAIL io_write_valid_cycles: got %0d want 3", n_iov - v0); end
    endtask

    task automatic test_io_read();
        int lat; logic [31:0] rd; logic er;
        io_respond = 1'b1; io_delay = 0;
        run_req(32'hF000_03FC, 32'h0, 1'b0, 1'b0, lat, rd, er);
        total++; if (lat !== 3) begin bad++; $display("FAIL io_read_lat: got %0d want 3", lat); end
        total++; if (rd !== 32'h5A5A_0001) begin bad++; $display("FAIL io_read_data: got %h want 5a5a0001", rd); end
        total++; if (last_ioa !== 8'hFF || last_iowe !== 1'b0) begin
            bad++; $display("FAIL io_read_addr: got %h we %b want ff we 0", last_ioa, last_iowe);
        end
    endtask

    task automatic test_io_timeout();
        int lat; logic [31:0] rd; logic er; int v0;
        io_respond = 1'b0;
        v0 = n_iov;
        run_req(32'hF000_0000, 32'h0, 1'b0, 1'b0, lat, rd, er);
        total++; if (lat !== 18) begin bad++; $display("FAIL io_timeout_lat: got %0d want 18", lat); end
        total++; if (rd !== 32'hFFFF_FFFF || er !== 1'b1) begin
            bad++; $display("FAIL io_timeout_result: got %h err %b want ffffffff err 1", rd, er);
        end
        total++; if (bus.errorAddress !== 32'hF000_0000) begin
            bad++; $display("FAIL io_timeout_erraddr: got %h want f0000000", bus.errorAddress);
        end
        total++; if (n_iov - v0 !== 16) begin bad++; $display("FAIL io_timeout_valid_cycles: got %0d want 16", n_iov - v0); end
    endtask

    task automatic test_errors();
        logic [31:0] ea [6];
        logic        ei [6];
        logic        ew [6];
        int lat; logic [31:0] rd; logic er; int c0, v0;
        ea = '{32'h8000_0000, 32'hF000_0004, 32'h0000_4000, 32'hF000_0400, 32'hEFFF_FFFC, 32'h0000_0020};
        ei = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            c0 = n_cs; v0 = n_iov;
            run_req(ea[k], 32'h1111_2222, ei[k], ew[k], lat, rd, er);
            // the final write-with-instr entry leaves cpuDataIn at the prior DEADBEEF
            total++; if (lat !== 2 || er !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
                bad++; $display("FAIL err_%0d_result: got lat %0d err %b data %h want 2 1 deadbeef", k, lat, er, rd);
            end
            total++; if (bus.errorAddress !== ea[k]) begin
                bad++; $display("FAIL err_%0d_addr: got %h want %h", k, bus.errorAddress, ea[k]);
            end
            total++; if (n_cs != c0 || n_iov != v0) begin
                bad++; $display("FAIL err_%0d_strobe: got cs %0d iov %0d want 0 0", k, n_cs - c0, n_iov - v0);
            end
        end
    endtask

    task automatic test_ioready_ignored();
        int lat; logic [31:0] rd; logic er; int v0;
        io_force = 1'b1; v0 = n_iov;
        run_req(32'h0000_0010, 32'h0, 1'b0, 1'b0, lat, rd, er);
        io_force = 1'b0;
        total++; if (lat !== 3 || rd !== 32'h1234_5678 || er !== 1'b0 || n_iov != v0) begin
            bad++; $display("FAIL ioready_ignored: got lat %0d data %h err %b iov %0d want 3 12345678 0 0",
                lat, rd, er, n_iov - v0);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er;
        io_respond = 1'b0;
        bus.cpuAddress = 32'hF000_0010; bus.cpuBusInstr = 1'b0;
        bus.cpuBusWriteEnable = 1'b0; bus.cpuBusValid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ioValid !== 1'b1) begin bad++; $display("FAIL midreset_pre: got ioValid %b want 1", ioValid); end
        bus.cpuBusValid = 1'b0;
        reset = 1'b0;
        #1;
        total++; if ({ioValid, ioWriteEnable, bus.cpuBusReady, bus.busError, ioAddress} !== 12'h0) begin
            bad++; $display("FAIL midreset_strobes: got %h want 000",
                {ioValid, ioWriteEnable, bus.cpuBusReady, bus.busError, ioAddress});
        end
        total++; if (bus.cpuDataIn !== 32'h0 || bus.errorAddress !== 32'h0) begin
            bad++; $display("FAIL midreset_data: got %h/%h want 0/0", bus.cpuDataIn, bus.errorAddress);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.cpuAddress = 32'h0000_0010; bus.cpuBusValid = 1'b1;
        @(negedge clk);
        total++; if ({ramChipSelect, ioValid, bus.cpuBusReady} !== 3'b0) begin
            bad++; $display("FAIL midreset_release: got %b want 000", {ramChipSelect, ioValid, bus.cpuBusReady});
        end
        @(posedge clk); #1;
        run_req(32'h0000_0010, 32'h0, 1'b0, 1'b0, lat, rd, er);
        total++; if (lat !== 3 || rd !== 32'h1234_5678 || er !== 1'b0) begin
            bad++; $display("FAIL midreset_next: got lat %0d data %h err %b want 3 12345678 0", lat, rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  csp, rp;
        logic [31:0] rd;
        csp = '0; rp = '0; rd = '0;
        bus.cpuAddress = 32'h0000_0010; bus.cpuBusInstr = 1'b0;
        bus.cpuBusWriteEnable = 1'b0; bus.cpuBusValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            csp[i] = ramChipSelect;
            rp[i]  = bus.cpuBusReady;
            if (i == 5) rd = bus.cpuDataIn;
            @(posedge clk); #1;
            if (i == 2) bus.cpuAddress = 32'h0000_0014;
        end
        bus.cpuBusValid = 1'b0;
        total++; if (csp !== 6'b001001) begin bad++; $display("FAIL b2b_cs: got %b want 001001", csp); end
        total++; if (rp !== 6'b100100) begin bad++; $display("FAIL b2b_ready: got %b want 100100", rp); end
        total++; if (rd !== 32'h1000_0005 || last_ram !== 12'd5) begin
            bad++; $display("FAIL b2b_second: got %h addr %h want 10000005 addr 005", rd, last_ram);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'h1234_5678;
        test_reset();
        test_ram_read();
        test_ram_write_boundary();
        test_io_write();
        test_io_read();
        test_io_timeout();
        test_errors();
        test_ioready_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
